enemy_draw_sequencer: RTL and testbench
=======================================

// Module: enemy_draw_sequencer
// PURPOSE
//  Generalised draw sequencer for N enemy sprite drawers sharing one VGA write port. On a
//  level draw request from control it grants each live enemy in ascending index order.
//  Dead enemies are skipped and hung drawers are aborted by a watchdog. Drawer pixel
//  streams are forwarded, registered, to the VGA path. Sits between control, the enemy
//  drawer instances and the VGA write mux; replaces the fixed 3-enemy chained draw logic.
// PARAMETERS
//  N_ENEMIES  3     number of enemy drawers (1..16)
//  IDX_W      2     width of index, >= clog2(N_ENEMIES)
//  X_W        9     x coordinate width
//  Y_W        8     y coordinate width
//  COLOUR_W   6     pixel colour width
//  TIMEOUT    1024  max cycles granted to one drawer before abort (>= 2)
// PORTS
//  clock       in   1                  system clock
//  reset       in   1                  synchronous, active-high
//  draw        in   1                  control draw state, level; low aborts/ends sequence
//  alive       in   N_ENEMIES          live mask; bit i=1 -> enemy i is drawn
//  e_x_draw    in   N_ENEMIES*X_W      drawer x, enemy i at [i*X_W +: X_W]
//  e_y_draw    in   N_ENEMIES*Y_W      drawer y, same packing
//  e_colour    in   N_ENEMIES*COLOUR_W drawer colour, same packing
//  e_write     in   N_ENEMIES          drawer VGA write strobes
//  e_done      in   N_ENEMIES          drawer done levels
//  draw_en     out  N_ENEMIES          per-drawer draw enable
//  x_draw      out  X_W                forwarded pixel x
//  y_draw      out  Y_W                forwarded pixel y
//  colour      out  COLOUR_W           forwarded pixel colour
//  VGA_write   out  1                  forwarded write strobe
//  draw_done   out  1                  all live enemies drawn; held while draw high
//  active_idx  out  IDX_W              index currently granted (debug)
//  timeout_err out  1                  sticky: some drawer hit TIMEOUT; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pending mask 0, watchdog 0.
//  - FSM states: IDLE, SCAN, RUN, DONE. draw low in any state -> IDLE next cycle.
//    On that cycle draw_en, VGA_write and draw_done clear together, and x_draw, y_draw
//    and colour clear to 0.
//  - IDLE: on draw=1, latch pending<=alive and go to SCAN. alive changes after this
//    edge are ignored until the next sequence.
//  - SCAN (1 cycle): i = lowest set bit of pending. If one exists, set draw_en[i]=1,
//    active_idx=i, watchdog=0 and go to RUN. If pending=0, go to DONE.
//  - RUN: register e_*[i] onto x_draw/y_draw/colour/VGA_write (latency 1 cycle; all four
//    fields stay aligned).
//    - If e_done[i]=1: clear pending[i], force VGA_write=0 and go to SCAN.
//    - Else, if watchdog=TIMEOUT-1: set timeout_err=1, clear pending[i], force
//      VGA_write=0 and go to SCAN.
//    - If e_done[i] and the timeout occur in the same cycle, done wins and no error is
//      flagged.
//  - draw_en bits, once set, stay set until the sequence ends (draw low), so finished
//    drawers hold their done level.
//  - DONE: draw_done=1 and VGA_write=0. Held until draw falls.
//  - Outputs are 0 in IDLE, SCAN and DONE, except draw_en, active_idx, timeout_err and
//    draw_done.
//  - alive=0 at start: draw_done rises 2 cycles after draw is sampled high.
//  - The watchdog saturates and does not wrap. Packed input slices for unused indices are
//    never selected.
// STRUCTURE
//  - Shared include enemy_defs.vh: FSM state encodings, default X_W/Y_W/COLOUR_W,
//    ON/OFF constants.
//  - One sub-module, enemy_lowest_set: parametrised priority encoder with
//    pending -> {found, idx}.
//  - Muxing and the FSM stay in this module.
// TESTING
//  1. N=3, alive=3'b111; each drawer done after 4 writes -> grants 0,1,2 in order,
//     12 VGA_write pulses, draw_done high.
//  2. alive=3'b101 -> enemy 1 never gets draw_en; draw_done after enemies 0 and 2 only.
//  3. alive=0, draw high -> draw_done=1 2 cycles later, no VGA_write, draw_en=0.
//  4. TIMEOUT=16, enemy 1 never asserts done -> enemy 1 aborted at 16 cycles,
//     timeout_err=1, enemy 2 still drawn, draw_done=1.
//  5. draw dropped mid-RUN of enemy 1 -> next cycle all draw_en=0, VGA_write=0;
//     redraw restarts from enemy 0.
//  6. Reset asserted mid-sequence -> all outputs 0 next cycle, timeout_err cleared.
//     Also check alive toggled during RUN does not alter the current grant order.

Source files
------------

// File: rtl/enemy_draw_sequencer_pkg.sv
// Shared definitions for the enemy draw sequencer: FSM encodings, default
// coordinate/colour widths and on/off constants.
package enemy_draw_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int X_W_DEF      = 9;
  localparam int Y_W_DEF      = 8;
  localparam int COLOUR_W_DEF = 6;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

endpackage

// File: rtl/enemy_lowest_set.sv
// Priority encoder: reports whether any pending bit is set and the index of
// the lowest one.
module enemy_lowest_set #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     pending,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_draw_sequencer.sv
// Grants live enemy drawers one at a time in ascending index order and
// forwards the granted drawer's pixel stream, registered, to the VGA port.
//
// state | meaning
// IDLE  | waiting for draw; latches the alive mask when it rises
// SCAN  | picks the lowest still-pending enemy, or finishes if none left
// RUN   | forwards the granted drawer until done or watchdog expiry
// DONE  | all live enemies drawn; draw_done held until draw falls
module enemy_draw_sequencer
  import enemy_draw_sequencer_pkg::*;
#(
  parameter int N_ENEMIES = 3,
  parameter int IDX_W     = 2,
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int COLOUR_W  = COLOUR_W_DEF,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          draw,
  input  logic [N_ENEMIES-1:0]          alive,
  input  logic [N_ENEMIES*X_W-1:0]      e_x_draw,
  input  logic [N_ENEMIES*Y_W-1:0]      e_y_draw,
  input  logic [N_ENEMIES*COLOUR_W-1:0] e_colour,
  input  logic [N_ENEMIES-1:0]          e_write,
  input  logic [N_ENEMIES-1:0]          e_done,
  output logic [N_ENEMIES-1:0]          draw_en,
  output logic [X_W-1:0]                x_draw,
  output logic [Y_W-1:0]                y_draw,
  output logic [COLOUR_W-1:0]           colour,
  output logic                          VGA_write,
  output logic                          draw_done,
  output logic [IDX_W-1:0]              active_idx,
  output logic                          timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_t state, state_nxt;
  logic [N_ENEMIES-1:0] pending, pending_nxt;
  logic [N_ENEMIES-1:0] draw_en_nxt;
  logic [IDX_W-1:0]     idx_nxt;
  logic [WD_W-1:0]      watchdog, watchdog_nxt;
  logic                 terr_nxt;
  logic [X_W-1:0]       x_nxt;
  logic [Y_W-1:0]       y_nxt;
  logic [COLOUR_W-1:0]  colour_nxt;
  logic                 write_nxt;
  logic                 done_nxt;

  logic                 found;
  logic [IDX_W-1:0]     found_idx;

  logic [X_W-1:0]       ex [N_ENEMIES];
  logic [Y_W-1:0]       ey [N_ENEMIES];
  logic [COLOUR_W-1:0]  ec [N_ENEMIES];
  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;
  logic [COLOUR_W-1:0]  cur_colour;
  logic                 cur_write;
  logic                 cur_done;

  for (genvar g = 0; g < N_ENEMIES; g++) begin : g_unpack
    assign ex[g] = e_x_draw[g*X_W +: X_W];
    assign ey[g] = e_y_draw[g*Y_W +: Y_W];
    assign ec[g] = e_colour[g*COLOUR_W +: COLOUR_W];
  end

  // active_idx only ever holds an encoder result, so it stays below N_ENEMIES.
  assign cur_x      = ex[active_idx];
  assign cur_y      = ey[active_idx];
  assign cur_colour = ec[active_idx];
  assign cur_write  = e_write[active_idx];
  assign cur_done   = e_done[active_idx];

  enemy_lowest_set #(
    .N     (N_ENEMIES),
    .IDX_W (IDX_W)
  ) u_lowest_set (
    .pending (pending),
    .found   (found),
    .idx     (found_idx)
  );

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    draw_en_nxt  = draw_en;
    idx_nxt      = active_idx;
    watchdog_nxt = watchdog;
    terr_nxt     = timeout_err;
    x_nxt        = '0;
    y_nxt        = '0;
    colour_nxt   = '0;
    write_nxt    = OFF;
    done_nxt     = OFF;

    if (!draw) begin
      state_nxt   = ST_IDLE;
      draw_en_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pending_nxt = alive;
          state_nxt   = ST_SCAN;
        end
        ST_SCAN: begin
          if (found) begin
            draw_en_nxt[found_idx] = ON;
            idx_nxt                = found_idx;
            watchdog_nxt           = '0;
            state_nxt              = ST_RUN;
          end else begin
            state_nxt = ST_DONE;
          end
        end
        ST_RUN: begin
          // Done takes priority over an expiring watchdog in the same cycle.
          if (cur_done) begin
            pending_nxt[active_idx] = OFF;
            state_nxt               = ST_SCAN;
          end else if (watchdog == WD_LAST) begin
            terr_nxt                = ON;
            pending_nxt[active_idx] = OFF;
            state_nxt               = ST_SCAN;
          end else begin
            x_nxt        = cur_x;
            y_nxt        = cur_y;
            colour_nxt   = cur_colour;
            write_nxt    = cur_write;
            watchdog_nxt = watchdog + WD_W'(1);
          end
        end
        ST_DONE: begin
          done_nxt = ON;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      draw_en     <= '0;
      active_idx  <= '0;
      watchdog    <= '0;
      timeout_err <= OFF;
      x_draw      <= '0;
      y_draw      <= '0;
      colour      <= '0;
      VGA_write   <= OFF;
      draw_done   <= OFF;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      draw_en     <= draw_en_nxt;
      active_idx  <= idx_nxt;
      watchdog    <= watchdog_nxt;
      timeout_err <= terr_nxt;
      x_draw      <= x_nxt;
      y_draw      <= y_nxt;
      colour      <= colour_nxt;
      VGA_write   <= write_nxt;
      draw_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_enemy_draw_sequencer.sv
// Self-checking bench: behavioural drawer models feed a pixel/grant scoreboard
// that an independent monitor drains against the DUT outputs.
module tb_enemy_draw_sequencer;

  localparam int N       = 3;
  localparam int IDX_W   = 2;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int C_W     = 6;
  localparam int TIMEOUT = 16;
  localparam int PIX_W   = X_W + Y_W + C_W;

  logic               clock = 1'b0;
  logic               reset;
  logic               draw;
  logic [N-1:0]       alive;
  logic [N*X_W-1:0]   e_x_draw;
  logic [N*Y_W-1:0]   e_y_draw;
  logic [N*C_W-1:0]   e_colour;
  logic [N-1:0]       e_write;
  logic [N-1:0]       e_done;
  logic [N-1:0]       draw_en;
  logic [X_W-1:0]     x_draw;
  logic [Y_W-1:0]     y_draw;
  logic [C_W-1:0]     colour;
  logic               VGA_write;
  logic               draw_done;
  logic [IDX_W-1:0]   active_idx;
  logic               timeout_err;

  always #5 clock = ~clock;

  enemy_draw_sequencer #(
    .N_ENEMIES (N),
    .IDX_W     (IDX_W),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .COLOUR_W  (C_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .draw        (draw),
    .alive       (alive),
    .e_x_draw    (e_x_draw),
    .e_y_draw    (e_y_draw),
    .e_colour    (e_colour),
    .e_write     (e_write),
    .e_done      (e_done),
    .draw_en     (draw_en),
    .x_draw      (x_draw),
    .y_draw      (y_draw),
    .colour      (colour),
    .VGA_write   (VGA_write),
    .draw_done   (draw_done),
    .active_idx  (active_idx),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [PIX_W-1:0] pq[$];
  int               gq[$];
  int               done_k[N];
  int               kc[N];
  int               wr_pct;
  logic             exp_terr;
  int               pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Each enabled drawer writes on random cycles and raises done at its own
  // cycle done_k. A write reaches the VGA port only if the sequence is still
  // live and the drawer is within its TIMEOUT-cycle window, whose last cycle is
  // the abort cycle.
  task automatic drawer_step();
    for (int i = 0; i < N; i++) begin
      logic [X_W-1:0] xv;
      logic [Y_W-1:0] yv;
      logic [C_W-1:0] cv;
      xv = X_W'($urandom);
      yv = Y_W'($urandom);
      cv = C_W'($urandom);
      e_x_draw[i*X_W +: X_W] = xv;
      e_y_draw[i*Y_W +: Y_W] = yv;
      e_colour[i*C_W +: C_W] = cv;
      if (!draw_en[i]) begin
        kc[i]      = 0;
        e_done[i]  = 1'b0;
        e_write[i] = 1'b0;
      end else begin
        e_done[i]  = (kc[i] >= done_k[i]);
        e_write[i] = !e_done[i] && (int'($urandom_range(0, 99)) < wr_pct);
        if (e_write[i] && kc[i] < TIMEOUT - 1 && draw && !reset)
          pq.push_back({xv, yv, cv});
        kc[i]++;
      end
    end
  endtask

  initial begin : monitor
    logic [N-1:0]     prev_en;
    logic [N-1:0]     rising;
    logic [N-1:0]     expm;
    logic [PIX_W-1:0] ep;
    int               eg;
    prev_en = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        prev_en = '0;
      end else begin
        rising = draw_en & ~prev_en;
        if (rising != '0) begin
          if (gq.size() == 0) begin
            check("grant_unexpected", 32'(rising), 32'(0));
          end else begin
            eg   = gq.pop_front();
            expm = N'(1) << eg;
            check("grant_order", 32'(rising), 32'(expm));
            check("active_idx", 32'(active_idx), 32'(eg));
          end
        end
        prev_en = draw_en;
        if (VGA_write === 1'b1) begin
          pulses++;
          if (pq.size() == 0) begin
            check("pixel_unexpected", 32'(VGA_write), 32'(0));
          end else begin
            ep = pq.pop_front();
            check("pixel", 32'({x_draw, y_draw, colour}), 32'(ep));
          end
        end
      end
    end
  end

  // mode: 0 full sequence, 1 drop draw mid-RUN of enemy 1, 2 reset mid-sequence
  task automatic run_seq(input logic [N-1:0] mask, input bit toggle, input int mode,
                         input int exp_pulses);
    int cyc;
    bit finished;
    draw = 1'b0;
    repeat (2) begin
      @(negedge clock);
      drawer_step();
    end
    pulses = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        gq.push_back(i);
        if (done_k[i] >= TIMEOUT) exp_terr = 1'b1;
      end
    end
    @(negedge clock);
    alive = mask;
    draw  = 1'b1;
    drawer_step();
    cyc = 0;
    finished = 1'b0;
    while (cyc < 500 && !finished) begin
      @(negedge clock);
      cyc++;
      if (toggle) alive = N'($urandom);
      if (mode == 1 && draw_en[1] && kc[1] == 2) begin
        draw = 1'b0;
        drawer_step();
        @(negedge clock);
        drawer_step();
        check("drop_draw_en", 32'(draw_en), 32'(0));
        check("drop_vga_write", 32'(VGA_write), 32'(0));
        check("drop_draw_done", 32'(draw_done), 32'(0));
        check("drop_pixel", 32'({x_draw, y_draw, colour}), 32'(0));
        check("drop_pq_empty", 32'(pq.size()), 32'(0));
        pq.delete();
        gq.delete();
        return;
      end
      if (mode == 2 && cyc == 6) begin
        reset = 1'b1;
        drawer_step();
        @(negedge clock);
        check("rst_draw_en", 32'(draw_en), 32'(0));
        check("rst_vga_write", 32'(VGA_write), 32'(0));
        check("rst_pixel", 32'({x_draw, y_draw, colour}), 32'(0));
        check("rst_draw_done", 32'(draw_done), 32'(0));
        check("rst_active_idx", 32'(active_idx), 32'(0));
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        reset = 1'b0;
        draw  = 1'b0;
        exp_terr = 1'b0;
        drawer_step();
        pq.delete();
        gq.delete();
        return;
      end
      drawer_step();
      if (draw_done === 1'b1) finished = 1'b1;
    end
    check("seq_finished", 32'(finished), 32'(1));
    check("draw_done", 32'(draw_done), 32'(1));
    check("timeout_err", 32'(timeout_err), 32'(exp_terr));
    check("draw_en_held", 32'(draw_en), 32'(mask));
    check("done_vga_write", 32'(VGA_write), 32'(0));
    check("done_pixel", 32'({x_draw, y_draw, colour}), 32'(0));
    check("pixels_drained", 32'(pq.size()), 32'(0));
    check("grants_drained", 32'(gq.size()), 32'(0));
    if (mask == '0) check("empty_done_latency", 32'(cyc), 32'(3));
    if (exp_pulses >= 0) check("write_pulses", 32'(pulses), 32'(exp_pulses));
    @(negedge clock);
    drawer_step();
    check("draw_done_held", 32'(draw_done), 32'(1));
    pq.delete();
    gq.delete();
  endtask

  initial begin : stimulus
    reset    = 1'b1;
    draw     = 1'b0;
    alive    = '0;
    e_x_draw = '0;
    e_y_draw = '0;
    e_colour = '0;
    e_write  = '0;
    e_done   = '0;
    exp_terr = 1'b0;
    wr_pct   = 100;
    pulses   = 0;
    for (int i = 0; i < N; i++) begin
      done_k[i] = 4;
      kc[i]     = 0;
    end
    repeat (3) @(negedge clock);
    check("reset_draw_en", 32'(draw_en), 32'(0));
    check("reset_pixel", 32'({x_draw, y_draw, colour}), 32'(0));
    check("reset_vga_write", 32'(VGA_write), 32'(0));
    check("reset_draw_done", 32'(draw_done), 32'(0));
    check("reset_active_idx", 32'(active_idx), 32'(0));
    check("reset_timeout_err", 32'(timeout_err), 32'(0));
    reset = 1'b0;

    // All alive, four writes each.
    run_seq(3'b111, 1'b0, 0, 12);
    // Enemy 1 dead.
    run_seq(3'b101, 1'b0, 0, 8);
    // Nobody alive.
    run_seq(3'b000, 1'b0, 0, 0);
    // Done arriving on the last watchdog cycle wins over the abort.
    done_k[0] = TIMEOUT - 1;
    done_k[1] = 2;
    done_k[2] = 4;
    run_seq(3'b011, 1'b0, 0, TIMEOUT - 1 + 2);

    // Random masks, write densities and done times, alive toggling mid-sequence.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) done_k[i] = int'($urandom_range(1, 8));
      wr_pct = int'($urandom_range(40, 100));
      run_seq(N'($urandom), 1'b1, 0, -1);
    end

    // Enemy 1 hangs: aborted after TIMEOUT cycles, enemy 2 still drawn.
    wr_pct    = 100;
    done_k[0] = 3;
    done_k[1] = 1000;
    done_k[2] = 3;
    run_seq(3'b111, 1'b0, 0, 3 + (TIMEOUT - 1) + 3);
    // Error stays set across a clean sequence.
    done_k[1] = 2;
    run_seq(3'b111, 1'b1, 0, 8);

    // Drop draw while enemy 1 runs, then a clean redraw from enemy 0.
    for (int i = 0; i < N; i++) done_k[i] = 5;
    run_seq(3'b111, 1'b0, 1, -1);
    run_seq(3'b111, 1'b0, 0, 15);

    // Reset mid-sequence clears the sticky error.
    run_seq(3'b111, 1'b0, 2, -1);
    wr_pct = 70;
    run_seq(3'b110, 1'b1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : global_bound
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
